// File: rtl/csa_accum_ctrl.sv
// Carry-save reduction accumulator with a handshake FSM.
// Optional macro CSA_RESOLVE_PIPE_EN splits the final add across two cycles.
module csa_accum_ctrl #(
  parameter int W     = 64,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_ops,
  input  logic              in_valid,
  input  logic [W-1:0]      in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [W+CNT_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy
);

  localparam int OW = W + CNT_W;

`ifdef CSA_RESOLVE_PIPE_EN
  localparam int H = OW / 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_RESOLVE,
    S_RESOLVE_HI,
    S_DONE
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_RESOLVE,
    S_DONE
  } state_t;
`endif

  state_t           r_state;
  logic [OW-1:0]    r_sum;
  logic [OW-1:0]    r_carry;
  logic [OW-1:0]    r_out_data;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic [OW-1:0]    w_op;
  logic [OW-1:0]    w_csa_s;
  logic [OW-1:0]    w_maj;
  logic [OW-1:0]    w_csa_c;
  logic             w_in_hs;
  logic             w_out_hs;

  assign w_op     = {{CNT_W{1'b0}}, in_data};
  assign w_csa_s  = r_sum ^ r_carry ^ w_op;
  assign w_maj    = (r_sum & r_carry)
                  | (r_sum & w_op)
                  | (r_carry & w_op);
  assign w_csa_c  = {w_maj[OW-2:0], 1'b0};
  assign w_in_hs  = r_in_ready & in_valid;
  assign w_out_hs = r_out_valid & out_ready;

`ifdef CSA_RESOLVE_PIPE_EN
  logic [H:0]      w_lo;
  logic [OW-H-1:0] w_hi;
  logic            r_lo_c;

  assign w_lo = {1'b0, r_sum[H-1:0]}
              + {1'b0, r_carry[H-1:0]};
  assign w_hi = r_sum[OW-1:H]
              + r_carry[OW-1:H]
              + {{(OW-H-1){1'b0}}, r_lo_c};
`else
  logic [OW-1:0] w_full;

  assign w_full = r_sum + r_carry;
`endif

  // Control FSM plus the carry-save datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sum       <= '0;
      r_carry     <= '0;
      r_out_data  <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef CSA_RESOLVE_PIPE_EN
      r_lo_c      <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt      <= num_ops;
            r_sum      <= '0;
            r_carry    <= '0;
            r_out_data <= '0;
            r_busy     <= 1'b1;
            if (num_ops == '0) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state    <= S_ACCUM;
              r_in_ready <= 1'b1;
            end
          end
        end
        S_ACCUM: begin
          if (w_in_hs) begin
            r_sum   <= w_csa_s;
            r_carry <= w_csa_c;
            r_cnt   <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_state    <= S_RESOLVE;
              r_in_ready <= 1'b0;
            end
          end
        end
`ifdef CSA_RESOLVE_PIPE_EN
        S_RESOLVE: begin
          r_out_data[H-1:0] <= w_lo[H-1:0];
          r_lo_c            <= w_lo[H];
          r_state           <= S_RESOLVE_HI;
        end
        S_RESOLVE_HI: begin
          r_out_data[OW-1:H] <= w_hi;
          r_state            <= S_DONE;
          r_out_valid        <= 1'b1;
        end
`else
        S_RESOLVE: begin
          r_out_data  <= w_full;
          r_state     <= S_DONE;
          r_out_valid <= 1'b1;
        end
`endif
        S_DONE: begin
          if (w_out_hs) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Self-checking bench for csa_accum_ctrl (W=8, CNT_W=4).
// Directed table of jobs, mid-job reset, then randomized jobs vs a sum model.
module tb_csa_accum_ctrl;

  localparam int W     = 8;
  localparam int CNT_W = 4;
  localparam int OW    = W + CNT_W;
`ifdef CSA_RESOLVE_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [3:0]    num_ops;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic          out_ready;
  logic          busy;

  csa_accum_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_ops   (num_ops),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  logic [7:0] ops [16];

  typedef struct {
    int         n;
    logic [7:0] base;
    logic [7:0] step;
    int         gm;
    int         stall;
    bit         noise;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // gm: 0 back-to-back, 1 toggle 1/0, 2 random in_valid
  task automatic do_job(input string nm, input int n, input int gm,
                        input int stall, input bit noise,
                        input logic [11:0] exp);
    int hs = 0;
    int cyc = 0;
    int last = -1;
    int vcyc = -1;
    int k = 0;
    int st = 0;
    int bad = 0;
    bit done = 1'b0;
    logic [11:0] res = '0;
    @(negedge clk);
    chk({nm, "_idle"}, 32'(busy), 32'd0);
    start = 1'b1;
    num_ops = 4'(n);
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (!done && cyc < 400) begin
      if (out_valid) begin
        if (vcyc < 0) begin
          vcyc = cyc;
          res = out_data;
        end else if (out_data !== res) begin
          bad++;
        end
        out_ready = (st >= stall);
        st++;
        if (out_ready) done = 1'b1;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      case (gm)
        0: in_valid = 1'b1;
        1: in_valid = (cyc % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = ops[k];
      if (in_valid && in_ready) begin
        hs++;
        last = cyc;
        if (k < 15) k++;
      end
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        num_ops = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_data"}, 32'(res), 32'(exp));
    chk({nm, "_hs"}, 32'(hs), 32'(n));
    chk({nm, "_stable"}, 32'(bad), 32'd0);
    if (n > 0) chk({nm, "_lat"}, 32'(vcyc - last - 1), 32'(LAT));
    else chk({nm, "_lat0"}, 32'(vcyc), 32'd0);
    chk({nm, "_ret_idle"}, {30'd0, busy, out_valid}, 32'd0);
  endtask

  initial begin
    int k;
    int g;
    int s;
    logic [7:0] v;
    rst_n = 1'b0;
    start = 1'b0;
    num_ops = '0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;

    tbl[0] = '{3,  8'hFF, 8'h00, 0, 0, 1'b0, 12'h2FD};
    tbl[1] = '{0,  8'h00, 8'h00, 0, 0, 1'b0, 12'h000};
    tbl[2] = '{15, 8'hFF, 8'h00, 1, 0, 1'b0, 12'hEF1};
    tbl[3] = '{2,  8'h01, 8'h01, 0, 5, 1'b1, 12'h003};
    tbl[4] = '{9,  8'h01, 8'h01, 2, 1, 1'b1, 12'h02D};
    tbl[5] = '{15, 8'h01, 8'h11, 0, 0, 1'b0, 12'h708};
    tbl[6] = '{1,  8'h80, 8'h00, 1, 2, 1'b0, 12'h080};
    tbl[7] = '{4,  8'h10, 8'h10, 2, 0, 1'b1, 12'h0A0};

    #12;
    chk("rst_outs", {19'd0, in_ready, out_valid, busy, out_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst", {19'd0, in_ready, out_valid, busy, out_data}, 32'd0);

    for (int t = 0; t < 8; t++) begin
      v = tbl[t].base;
      for (int i = 0; i < 16; i++) begin
        ops[i] = v;
        v = v + tbl[t].step;
      end
      do_job($sformatf("vec%0d", t), tbl[t].n, tbl[t].gm,
             tbl[t].stall, tbl[t].noise, tbl[t].exp);
    end

    // reset in the middle of a 4-operand job after 2 handshakes
    @(negedge clk);
    start = 1'b1;
    num_ops = 4'd4;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    g = 0;
    while (k < 2 && g < 50) begin
      in_valid = 1'b1;
      in_data = 8'h55;
      if (in_ready) k++;
      @(negedge clk);
      g++;
    end
    in_valid = 1'b0;
    chk("mid_accepted", 32'(k), 32'd2);
    chk("mid_busy", {30'd0, busy, in_ready}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst", {19'd0, in_ready, out_valid, busy, out_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_after", {19'd0, in_ready, out_valid, busy, out_data}, 32'd0);
    ops[0] = 8'h01;
    ops[1] = 8'h02;
    do_job("after_rst", 2, 0, 0, 1'b0, 12'h003);

    // randomized jobs against a plain-sum model
    for (int r = 0; r < 25; r++) begin
      int n;
      n = $urandom_range(0, 15);
      s = 0;
      for (int i = 0; i < 16; i++) ops[i] = 8'($urandom);
      for (int i = 0; i < n; i++) s += int'(ops[i]);
      do_job($sformatf("rnd%0d", r), n, 2,
             $urandom_range(0, 3), 1'b1, 12'(s));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
